// File: rtl/dinogame_pkg.sv
// Shared constants for the score display path: converter FSM states and
// decimal saturation limits.
package dinogame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [3:0] DIGIT_NINE = 4'h9;

  // Largest value representable in n decimal digits (10^n - 1), n = 1..9.
  function automatic logic [31:0] bcd_max(input int unsigned n);
    case (n)
      1:       return 32'd9;
      2:       return 32'd99;
      3:       return 32'd999;
      4:       return 32'd9999;
      5:       return 32'd99999;
      6:       return 32'd999999;
      7:       return 32'd9999999;
      8:       return 32'd99999999;
      default: return 32'd999999999;
    endcase
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (one bit per clock) with leading-zero
// blanking and saturation to all nines when the value exceeds the digit count.
module score_bcd_converter
  import dinogame_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 32,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int unsigned       BCD_W     = 4 * DIGITS;
  localparam int unsigned       CNT_W     = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0]       LIMIT     = 64'(bcd_max(DIGITS));
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  conv_state_t          state, state_next;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     scratch_adj;
  logic [BCD_W-1:0]     final_bcd;
  logic [CNT_W-1:0]     count;
  logic                 ovf_pending;
  logic [DIGITS-1:0]    blank_next;
  logic                 all_zero;
  int unsigned          idx;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == CNT_W'(BIN_WIDTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Walk from the top digit down; a digit is blanked only while every digit
  // above it (and itself) is zero. Digit 0 is never blanked.
  always_comb begin
    final_bcd  = ovf_pending ? {DIGITS{DIGIT_NINE}} : scratch;
    blank_next = '0;
    all_zero   = 1'b1;
    idx        = 0;
    for (int unsigned j = 0; j < DIGITS - 1; j++) begin
      idx             = DIGITS - 1 - j;
      all_zero        = all_zero & (scratch[4*idx +: 4] == 4'd0);
      blank_next[idx] = all_zero;
    end
    if (ovf_pending) blank_next = '0;
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      scratch     <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      done        <= 1'b0;
      bcd_out     <= '0;
      blank       <= BLANK_RST;
      overflow    <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg   <= bin_in;
            scratch     <= '0;
            count       <= '0;
            ovf_pending <= (64'(bin_in) > LIMIT);
          end
        end
        SHIFT: begin
          // Carry out of the top digit is dropped; saturation covers that case.
          {scratch, shift_reg} <= {scratch_adj[BCD_W-2:0], shift_reg, 1'b0};
          count                <= count + CNT_W'(1);
        end
        DONE: begin
          bcd_out  <= final_bcd;
          overflow <= ovf_pending;
          blank    <= blank_next;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Bench for score_bcd_converter: directed corner cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_score_bcd_converter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic [3:0]  blank;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  score_bcd_converter #(
    .BIN_WIDTH (32),
    .DIGITS    (4)
  ) dut (
    .Clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .blank    (blank),
    .overflow (overflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the input value.
  task automatic model(input logic [31:0] v, output logic [15:0] bcd,
                       output logic [3:0] blk, output logic ovf);
    longint unsigned x;
    x = v;
    bcd = '0;
    blk = '0;
    ovf = 1'b0;
    if (x > 9999) begin
      bcd = 16'h9999;
      ovf = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) bcd[4*i +: 4] = 4'((x / (10 ** i)) % 10);
      for (int i = 1; i < 4; i++) blk[i] = (x < longint'(10 ** i));
    end
  endtask

  task automatic check_outputs(input logic [31:0] v, input string tag);
    logic [15:0] e_bcd;
    logic [3:0]  e_blk;
    logic        e_ovf;
    model(v, e_bcd, e_blk, e_ovf);
    check_eq({tag, "/bcd"}, 64'(bcd_out), 64'(e_bcd));
    check_eq({tag, "/blank"}, 64'(blank), 64'(e_blk));
    check_eq({tag, "/ovf"}, 64'(overflow), 64'(e_ovf));
  endtask

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic run_conv(input logic [31:0] v, input bit scramble, input string tag);
    int          m;
    int          busy_cycles;
    int          changes;
    bit          seen;
    logic [15:0] prev;
    prev   = bcd_out;
    bin_in = v;
    start  = 1'b1;
    @(negedge clock);
    start       = 1'b0;
    m           = 0;
    busy_cycles = 0;
    changes     = 0;
    seen        = 1'b0;
    while (!seen && m < 100) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        if (bcd_out !== prev) changes++;
        if (scramble) bin_in = $urandom;
        @(negedge clock);
        m++;
      end
    end
    check_eq({tag, "/done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, "/latency"}, 64'(m), 64'd33);
    check_eq({tag, "/busy_cycles"}, 64'(busy_cycles), 64'd33);
    check_eq({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    check_eq({tag, "/hold"}, 64'(changes), 64'd0);
    check_outputs(v, tag);
  endtask

  initial begin
    int          m;
    int          pulses;
    int          first_done;
    logic [31:0] v;

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clock);
    check_eq("rst/busy", 64'(busy), 64'd0);
    check_eq("rst/done", 64'(done), 64'd0);
    check_eq("rst/bcd", 64'(bcd_out), 64'd0);
    check_eq("rst/blank", 64'(blank), 64'he);
    check_eq("rst/ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_conv(32'd1234, 1'b0, "d1234");
    run_conv(32'd0, 1'b0, "d0");
    run_conv(32'd7, 1'b0, "d7");
    run_conv(32'd305, 1'b0, "d305");
    run_conv(32'd9999, 1'b0, "d9999");
    run_conv(32'd10000, 1'b0, "d10000");
    run_conv(32'hFFFF_FFFF, 1'b0, "dmax");

    // start re-pulsed while busy, including in the DONE cycle
    bin_in = 32'd42;
    start  = 1'b1;
    @(negedge clock);
    start      = 1'b0;
    pulses     = 0;
    first_done = -1;
    for (m = 0; m < 40; m++) begin
      if (done) begin
        pulses++;
        first_done = m;
        break;
      end
      start  = (m == 4 || m == 32);
      bin_in = start ? 32'd77 : bin_in;
      @(negedge clock);
    end
    start = 1'b0;
    check_eq("busy_start/pulses", 64'(pulses), 64'd1);
    check_eq("busy_start/latency", 64'(first_done), 64'd33);
    check_outputs(32'd42, "busy_start");
    run_conv(32'd77, 1'b0, "after_done77");

    // reset mid-conversion, with start held high alongside reset
    run_conv(32'd58, 1'b0, "d58");
    bin_in = 32'd9000;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check_eq("midrst/busy", 64'(busy), 64'd0);
    check_eq("midrst/done", 64'(done), 64'd0);
    check_eq("midrst/bcd", 64'(bcd_out), 64'd0);
    check_eq("midrst/blank", 64'(blank), 64'he);
    check_eq("midrst/ovf", 64'(overflow), 64'd0);
    pulses = 0;
    for (m = 0; m < 40; m++) begin
      if (done) pulses++;
      @(negedge clock);
    end
    check_eq("midrst/no_done", 64'(pulses), 64'd0);
    run_conv(32'd9000, 1'b0, "d9000");

    run_conv(32'd2468, 1'b1, "scramble2468");

    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 9999);
        2:       v = $urandom_range(9990, 10010);
        default: v = $urandom;
      endcase
      run_conv(v, (i % 3) == 0, $sformatf("rand%0d", i));
    end

    @(negedge clock);
    check_eq("tail/done", 64'(done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
